// File: rtl/ifetch_pkg.sv
// Shared CPU constants and fetch-path types.
// Used by the fetch unit and its instruction queue.
package ifetch_pkg;

  localparam int WORD_WIDTH = 32;
  localparam int PC_STEP = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int ENTRY_WIDTH = 2 * WORD_WIDTH;

  typedef logic [WORD_WIDTH-1:0] word_t;

  typedef struct packed {
    word_t pc;
    word_t instr;
  } fetch_entry_t;

  function automatic logic misaligned(input word_t a);
    return a[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Instruction queue: DEPTH x {pc, instr}, flushable.
// When empty the head output holds the last entry shown.
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t wdata,
  output fetch_entry_t rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t   r_mem [DEPTH];
  fetch_entry_t   r_last;
  logic [AW-1:0]  r_rd;
  logic [AW-1:0]  r_wr;
  logic [AW:0]    r_count;
  logic           w_push;
  logic           w_pop;

  assign full  = r_count == (AW+1)'(DEPTH);
  assign empty = r_count == '0;
  assign rdata = empty ? r_last : r_mem[r_rd];

  assign w_pop  = pop & ~empty;
  assign w_push = push & (~full | w_pop);

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr] <= wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
      r_last  <= '0;
    end else if (flush) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
      r_last  <= rdata;
    end else begin
      if (w_push) begin
        r_wr <= r_wr + 1'b1;
      end
      if (w_pop) begin
        r_rd   <= r_rd + 1'b1;
        r_last <= rdata;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch: PC register, imem handshake,
// redirect/flush and sticky misaligned-fetch fault.
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter word_t RESET_PC = DEFAULT_RESET_PC,
  parameter int    DEPTH    = 4
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_instruction,
  input  logic        imem_ready,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        fetch_fault
);

  localparam word_t STEP = word_t'(PC_STEP);

  word_t        r_fpc;
  logic         r_fault;
  logic         w_full;
  logic         w_empty;
  logic         w_push;
  logic         w_pop;
  fetch_entry_t w_head;
  fetch_entry_t w_in;

  assign imem_address = r_fpc;
  assign fetch_fault  = r_fault;
  assign inst_valid   = ~w_empty;
  assign inst_pc      = w_head.pc;
  assign inst_data    = w_head.instr;

  assign w_in.pc    = r_fpc;
  assign w_in.instr = imem_instruction;

  // A redirect cancels both sides of the queue that cycle.
  assign w_pop  = inst_valid & inst_ready & ~redirect;
  assign w_push = imem_ready & ~r_fault & ~redirect
                & (~w_full | w_pop);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_fpc   <= RESET_PC;
      r_fault <= 1'b0;
    end else if (redirect) begin
      r_fpc   <= redirect_pc;
      r_fault <= misaligned(redirect_pc);
    end else if (w_push) begin
      r_fpc   <= r_fpc + STEP;
    end
  end

  ifetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock(clock),
    .reset(reset),
    .flush(redirect),
    .push (w_push),
    .pop  (w_pop),
    .wdata(w_in),
    .rdata(w_head),
    .full (w_full),
    .empty(w_empty)
  );

endmodule
